// File: rtl/ex_stage_pipe_pkg.sv
// Shared definitions for the execute stage: ALU operation encodings and
// the hardwired-zero register index.
package ex_stage_pipe_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_PASSB = 3'b110
  } alu_op_e;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/ex_stage_pipe_alu.sv
// Combinational ALU for the execute stage; carry is meaningful only for
// ADD/SUB and reads 0 for every other operation.
module ex_alu
  import ex_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_SUB: begin
        result = diff[DATA_W-1:0];
        // Top bit of the widened difference is the borrow.
        carry  = ~diff[DATA_W];
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT:   result[0] = $signed(a) < $signed(b);
      ALU_PASSB: result = b;
      default: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
    endcase
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: two-level operand forwarding, sign-extended immediate,
// ALU, and a valid/ready EX/WB output register.
module ex_stage_pipe
  import ex_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RADDR_W = 3,
  parameter int unsigned IMM_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]  in_data1,
  input  logic [DATA_W-1:0]  in_data2,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               in_use_imm,
  input  logic [2:0]         in_alu_op,
  input  logic               in_wreg,
  input  logic               in_to_reg,
  input  logic               wb_wreg,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wreg,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_zero,
  output logic               out_carry
);

  logic              accept;
  logic              load;
  logic [DATA_W-1:0] ext_imm;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [DATA_W-1:0] result_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = accept && !flush;

  // The EX/WB entry is younger than WB, so it is checked first.
  always_comb begin
    ext_imm = DATA_W'($signed(in_imm));

    op_a = in_data1;
    if (out_valid && out_wreg && out_rd == in_rs1 && in_rs1 != RADDR_W'(ZERO_REG))
      op_a = out_result;
    else if (wb_wreg && wb_rd == in_rs1 && in_rs1 != RADDR_W'(ZERO_REG))
      op_a = wb_data;

    fwd_b = in_data2;
    if (out_valid && out_wreg && out_rd == in_rs2 && in_rs2 != RADDR_W'(ZERO_REG))
      fwd_b = out_result;
    else if (wb_wreg && wb_rd == in_rs2 && in_rs2 != RADDR_W'(ZERO_REG))
      fwd_b = wb_data;

    op_b        = in_use_imm ? ext_imm : fwd_b;
    result_next = in_to_reg ? alu_result : ext_imm;
  end

  ex_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (in_alu_op),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rd     <= '0;
      out_wreg   <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
    end else if (load) begin
      out_rd     <= in_rd;
      out_wreg   <= in_wreg;
      out_result <= result_next;
      out_zero   <= (result_next == '0);
      out_carry  <= alu_carry;
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: directed cases plus random traffic
// checked against an arithmetic reference model.
module tb_ex_stage_pipe;

  localparam int DW  = 8;
  localparam int RW  = 3;
  localparam int IW  = 3;
  localparam int MOD = 1 << DW;

  typedef struct {
    int rd;
    int wreg;
    int result;
    int zero;
    int carry;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_rs1, in_rs2, in_rd;
  logic [DW-1:0] in_data1, in_data2;
  logic [IW-1:0] in_imm;
  logic          in_use_imm;
  logic [2:0]    in_alu_op;
  logic          in_wreg, in_to_reg;
  logic          wb_wreg;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          out_valid, out_ready;
  logic [RW-1:0] out_rd;
  logic          out_wreg;
  logic [DW-1:0] out_result;
  logic          out_zero, out_carry;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  // Reference-model view of what the EX/WB register holds.
  int m_valid = 0;
  int m_rd    = 0;
  int m_wreg  = 0;
  int m_result = 0;

  ex_stage_pipe #(.DATA_W(DW), .RADDR_W(RW), .IMM_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
    .in_wreg(in_wreg), .in_to_reg(in_to_reg),
    .wb_wreg(wb_wreg), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_wreg(out_wreg), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd(input int rs, input int d);
    if (m_valid != 0 && m_wreg != 0 && m_rd == rs && rs != 0) return m_result;
    if (wb_wreg && int'(wb_rd) == rs && rs != 0) return int'(wb_data);
    return d;
  endfunction

  function automatic exp_t model();
    exp_t e;
    int a, b, ext, simm, sa, sb, s, r, c;
    simm = int'(in_imm);
    if (simm >= (1 << (IW - 1))) simm -= (1 << IW);
    ext = (simm + MOD) % MOD;
    a = fwd(int'(in_rs1), int'(in_data1));
    b = in_use_imm ? ext : fwd(int'(in_rs2), int'(in_data2));
    sa = (a >= MOD / 2) ? a - MOD : a;
    sb = (b >= MOD / 2) ? b - MOD : b;
    c = 0;
    case (int'(in_alu_op))
      1: begin r = (a - b + MOD) % MOD; c = (a >= b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = b;
      default: begin s = a + b; r = s % MOD; c = (s >= MOD) ? 1 : 0; end
    endcase
    e.rd     = int'(in_rd);
    e.wreg   = int'(in_wreg);
    e.result = in_to_reg ? r : ext;
    e.zero   = (e.result == 0) ? 1 : 0;
    e.carry  = c;
    return e;
  endfunction

  // One clock with the currently driven inputs; returns at posedge+1.
  task automatic drive_cycle();
    int   acc;
    exp_t e;
    @(negedge clk);
    chk("in_ready", int'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
    acc = (in_valid && (m_valid == 0 || out_ready)) ? 1 : 0;
    e = model();
    if (acc != 0 && !flush) sb_q.push_back(e);
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (acc != 0) begin
      m_valid = 1; m_rd = e.rd; m_wreg = e.wreg; m_result = e.result;
    end else if (out_ready) m_valid = 0;
    #1;
  endtask

  task automatic set_idle();
    flush = 0; in_valid = 0; out_ready = 1;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_data1 = '0; in_data2 = '0;
    in_imm = '0; in_use_imm = 0; in_alu_op = '0; in_wreg = 0; in_to_reg = 1;
    wb_wreg = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic set_instr(input int op, input int rs1, input int rs2, input int rd,
                           input int d1, input int d2, input int imm, input int use_imm);
    in_valid = 1; in_alu_op = 3'(op);
    in_rs1 = RW'(rs1); in_rs2 = RW'(rs2); in_rd = RW'(rd);
    in_data1 = DW'(d1); in_data2 = DW'(d2); in_imm = IW'(imm);
    in_use_imm = use_imm[0]; in_wreg = 1; in_to_reg = 1;
  endtask

  // Monitor: retires the presented entry on consume, drops it on flush.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && (out_ready || flush)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_out", 1, 0);
      end else begin
        e = sb_q.pop_front();
        if (!flush) begin
          chk("sb_rd", int'(out_rd), e.rd);
          chk("sb_wreg", int'(out_wreg), e.wreg);
          chk("sb_result", int'(out_result), e.result);
          chk("sb_zero", int'(out_zero), e.zero);
          chk("sb_carry", int'(out_carry), e.carry);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_rd"}, int'(out_rd), 0);
    chk({tag, "_wreg"}, int'(out_wreg), 0);
    chk({tag, "_result"}, int'(out_result), 0);
    chk({tag, "_zero"}, int'(out_zero), 0);
    chk({tag, "_carry"}, int'(out_carry), 0);
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;

    // ADD 0x7F + sext(3'b111) = 0x7E with carry.
    set_instr(0, 1, 0, 1, 8'h7F, 0, 3'b111, 1);
    drive_cycle();
    chk("add_result", int'(out_result), 8'h7E);
    chk("add_carry", int'(out_carry), 1);
    // SUB 5-5 = 0, zero and no-borrow carry set.
    set_instr(1, 0, 0, 4, 8'h05, 8'h05, 0, 0);
    drive_cycle();
    chk("sub_result", int'(out_result), 0);
    chk("sub_zero", int'(out_zero), 1);
    chk("sub_carry", int'(out_carry), 1);

    // EX/WB forward beats WB forward; then WB forward alone.
    set_instr(0, 1, 0, 2, 8'h10, 0, 0, 1);
    drive_cycle();
    set_instr(0, 2, 0, 3, 8'h00, 0, 0, 1);
    wb_wreg = 1; wb_rd = 3'd2; wb_data = 8'h33;
    drive_cycle();
    chk("fwd_ex_wins", int'(out_result), 8'h10);
    set_instr(0, 2, 0, 5, 8'h00, 0, 0, 1);
    drive_cycle();
    chk("fwd_wb", int'(out_result), 8'h33);

    // Register 0 never forwards, even from a writing rd=0 entry.
    set_instr(0, 1, 0, 0, 8'h55, 0, 0, 1);
    wb_wreg = 0;
    drive_cycle();
    set_instr(0, 0, 0, 6, 8'h21, 8'h12, 0, 0);
    wb_wreg = 1; wb_rd = 3'd0; wb_data = 8'hFF;
    drive_cycle();
    chk("no_fwd_r0", int'(out_result), 8'h33);
    wb_wreg = 0;

    // Stall three cycles: no accept, held entry unchanged.
    set_instr(4, 0, 0, 7, 8'hA5, 8'h0F, 0, 0);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      chk("stall_valid", int'(out_valid), 1);
      if (sb_q.size() > 0) begin
        chk("stall_result", int'(out_result), sb_q[0].result);
        chk("stall_rd", int'(out_rd), sb_q[0].rd);
      end
    end
    out_ready = 1;
    drive_cycle();
    chk("release_result", int'(out_result), 8'hAA);
    in_valid = 0;
    drive_cycle();

    // Flush with accept, then flush while stalled.
    set_instr(0, 0, 0, 1, 8'h01, 0, 1, 1);
    flush = 1;
    drive_cycle();
    chk("flush_accept_valid", int'(out_valid), 0);
    flush = 0;
    drive_cycle();
    out_ready = 0; in_valid = 0;
    drive_cycle();
    flush = 1;
    drive_cycle();
    chk("flush_stall_valid", int'(out_valid), 0);
    flush = 0; out_ready = 1;
    set_instr(5, 0, 0, 2, 8'h80, 0, 1, 1);
    drive_cycle();
    chk("slt_valid", int'(out_valid), 1);
    chk("slt_result", int'(out_result), 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      in_rs1     = RW'($urandom); in_rs2 = RW'($urandom); in_rd = RW'($urandom);
      in_data1   = DW'($urandom); in_data2 = DW'($urandom);
      in_imm     = IW'($urandom); in_use_imm = 1'($urandom);
      in_alu_op  = 3'($urandom); in_wreg = 1'($urandom); in_to_reg = ($urandom_range(0, 3) != 0);
      wb_wreg    = 1'($urandom); wb_rd = RW'($urandom); wb_data = DW'($urandom);
      drive_cycle();
    end

    // Async reset mid-stream while holding a valid entry.
    set_instr(2, 1, 2, 3, 8'hF0, 8'h3C, 0, 0);
    out_ready = 0; flush = 0; wb_wreg = 0;
    drive_cycle();
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    chk_all_zero("async_reset");
    sb_q.delete();
    m_valid = 0;
    #4 rst_n = 1;
    @(posedge clk); #1;

    set_idle();
    set_instr(3, 0, 0, 4, 8'h0C, 8'h30, 0, 0);
    drive_cycle();
    chk("post_reset_or", int'(out_result), 8'h3C);
    set_idle();
    for (int i = 0; i < 4; i++) drive_cycle();
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
